uart_shift_reg: RTL and testbench

Parametrised shift register for the UART datapath. It replaces the fixed 4-bit enable flip-flop with a WIDTH-bit register that supports hold, parallel load, and right or left serial shift. A shift counter emits a one-cycle `done` pulse once a full word has been shifted. The UART transmitter uses it as a parallel-in/serial-out (PISO) stage and the receiver as a serial-in/parallel-out (SIPO) stage.

---
 rtl/uart_shift_reg.sv | 100 ++++++++++
 tb/tb_uart_shift_reg.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/uart_shift_reg.sv
// WIDTH-bit hold/load/shift register with a word-completion counter for the UART datapath.
// Optional registered parity output is enabled by defining UART_SHIFT_PARITY_EN.
module uart_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic [CW-1:0]    cnt,
    output logic             done,
    output logic             parity
);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_LOAD  = 2'b01;
    localparam logic [1:0] MODE_SHR   = 2'b10;
    localparam logic [1:0] MODE_SHL   = 2'b11;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] q_nxt;
    logic [CW-1:0]    cnt_nxt;
    logic             done_nxt;
    logic             shifting;

    // Next-state logic; clr behaves like reset but stays out of the reset path.
    always_comb begin
        q_nxt    = q;
        cnt_nxt  = cnt;
        done_nxt = 1'b0;
        shifting = 1'b0;
        if (clr) begin
            q_nxt   = '0;
            cnt_nxt = '0;
        end else if (en) begin
            case (mode)
                MODE_HOLD: begin
                    q_nxt = q;
                end
                MODE_LOAD: begin
                    q_nxt   = d;
                    cnt_nxt = '0;
                end
                MODE_SHR: begin
                    q_nxt    = {sin, q[WIDTH-1:1]};
                    shifting = 1'b1;
                end
                MODE_SHL: begin
                    q_nxt    = {q[WIDTH-2:0], sin};
                    shifting = 1'b1;
                end
                default: begin
                    q_nxt = q;
                end
            endcase
            if (shifting) begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt  = '0;
                    done_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            q    <= q_nxt;
            cnt  <= cnt_nxt;
            done <= done_nxt;
        end
    end

    // sout is the bit the next shift in the selected direction will drop.
    assign sout = (mode == MODE_SHL) ? q[WIDTH-1] : q[0];

`ifdef UART_SHIFT_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            parity <= 1'b0;
        end else begin
            parity <= ^q_nxt;
        end
    end
`else
    assign parity = 1'b0;
`endif

endmodule

// File: tb/tb_uart_shift_reg.sv
// Directed bench for uart_shift_reg (WIDTH=8) with an expected-value queue.
module tb_uart_shift_reg;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         clr;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] d;
    logic         sin;
    logic [W-1:0] q;
    logic         sout;
    logic [2:0]   cnt;
    logic         done;
    logic         parity;

    int total;
    int bad;

    // expected {q, cnt, done, parity}
    logic [W+4:0] exp_q[$];

    uart_shift_reg #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .mode(mode), .d(d),
        .sin(sin), .q(q), .sout(sout), .cnt(cnt), .done(done), .parity(parity)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic exp_par(input logic [W-1:0] v);
`ifdef UART_SHIFT_PARITY_EN
        return ^v;
`else
        return 1'b0 & v[0];
`endif
    endfunction

    // Drive one cycle of stimulus, queue its expected result, then check after the edge.
    task automatic step(input string tag, input logic i_clr, input logic i_en,
                        input logic [1:0] i_mode, input logic [W-1:0] i_d, input logic i_sin,
                        input logic [W-1:0] eq, input logic [2:0] ec, input logic ed);
        logic [W+4:0] e;
        clr  = i_clr;
        en   = i_en;
        mode = i_mode;
        d    = i_d;
        sin  = i_sin;
        exp_q.push_back({eq, ec, ed, exp_par(eq)});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({tag, ".q"},    q,             e[W+4:5]);
        check({tag, ".cnt"},  W'(cnt),       W'(e[4:2]));
        check({tag, ".done"}, W'(done),      W'(e[1]));
        check({tag, ".par"},  W'(parity),    W'(e[0]));
    endtask

    initial begin
        logic [W-1:0] eq;
        logic [W-1:0] pat;
        logic [W-1:0] sipo;
        total = 0;
        bad   = 0;

        // Reset held two cycles while a load is requested
        rst = 1'b1; clr = 1'b0; en = 1'b1; mode = 2'b01; d = 8'hA5; sin = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("rst.q",    q,          8'h00);
            check("rst.cnt",  W'(cnt),    8'h00);
            check("rst.done", W'(done),   8'h00);
            check("rst.par",  W'(parity), 8'h00);
        end
        rst = 1'b0;

        // PISO, LSB first
        step("load_a5", 1'b0, 1'b1, 2'b01, 8'hA5, 1'b0, 8'hA5, 3'd0, 1'b0);
        pat = 8'hA5;
        eq  = 8'hA5;
        for (int k = 1; k <= W; k++) begin
            mode = 2'b10;
            #1;
            check("piso.sout", W'(sout), W'(pat[k-1]));
            eq = {1'b1, eq[W-1:1]};
            step("piso", 1'b0, 1'b1, 2'b10, 8'h00, 1'b1, eq, 3'(k % W), k == W);
        end
        check("piso.final", q, 8'hFF);
        step("piso_after", 1'b0, 1'b1, 2'b00, 8'h00, 1'b0, 8'hFF, 3'd0, 1'b0);

        // SIPO, MSB first, en low for 2 cycles after the third bit
        sipo = 8'b1100_1010;
        eq   = 8'hFF;
        for (int k = 0; k < W; k++) begin
            mode = 2'b11;
            #1;
            check("sipo.sout", W'(sout), W'(eq[W-1]));
            eq = {eq[W-2:0], sipo[W-1-k]};
            step("sipo", 1'b0, 1'b1, 2'b11, 8'h00, sipo[W-1-k], eq, 3'((k + 1) % W), k == W - 1);
            if (k == 2) begin
                step("sipo_gap", 1'b0, 1'b0, 2'b11, 8'h00, 1'b1, eq, 3'd3, 1'b0);
                step("sipo_gap", 1'b0, 1'b0, 2'b11, 8'h00, 1'b1, eq, 3'd3, 1'b0);
            end
        end
        check("sipo.final", q, 8'hCA);

        // Hold with en low even though a load is requested
        step("en_low_load", 1'b0, 1'b0, 2'b01, 8'h11, 1'b0, 8'hCA, 3'd0, 1'b0);

        // Clear mid-word
        eq = 8'hCA;
        for (int k = 1; k <= 5; k++) begin
            eq = {1'b0, eq[W-1:1]};
            step("clr_pre", 1'b0, 1'b1, 2'b10, 8'h00, 1'b0, eq, 3'(k), 1'b0);
        end
        step("clr", 1'b1, 1'b0, 2'b10, 8'h55, 1'b1, 8'h00, 3'd0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            step("clr_post", 1'b0, 1'b1, 2'b10, 8'h00, 1'b0, 8'h00, 3'(k), 1'b0);
        end

        // Load mid-word at cnt=6
        for (int k = 4; k <= 6; k++) begin
            step("ld_pre", 1'b0, 1'b1, 2'b11, 8'h00, 1'b0, 8'h00, 3'(k), 1'b0);
        end
        step("ld_3c", 1'b0, 1'b1, 2'b01, 8'h3C, 1'b0, 8'h3C, 3'd0, 1'b0);
        eq = 8'h3C;
        for (int k = 1; k <= W; k++) begin
            eq = {1'b0, eq[W-1:1]};
            step("ld_post", 1'b0, 1'b1, 2'b10, 8'h00, 1'b0, eq, 3'(k % W), k == W);
        end

        // Parity
        step("par_07", 1'b0, 1'b1, 2'b01, 8'h07, 1'b0, 8'h07, 3'd0, 1'b0);
        step("par_03", 1'b0, 1'b1, 2'b10, 8'h00, 1'b0, 8'h03, 3'd1, 1'b0);

        // Random right-shift stream followed by mode-hold checks
        eq = 8'h03;
        for (int k = 2; k <= 9; k++) begin
            logic b;
            b  = 1'($urandom_range(0, 1));
            eq = {b, eq[W-1:1]};
            step("rand", 1'b0, 1'b1, 2'b10, 8'h00, b, eq, 3'(k % W), k == W);
        end
        step("hold", 1'b0, 1'b1, 2'b00, 8'hFF, 1'b1, eq, 3'd1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
